// File: rtl/sort_chain_multi.sv
// K-best insertion-sorting chain: keeps the DEPTH best samples of a frame ordered
// by channel 0 and drains them serially, best first, with payload channels attached.
module sort_chain_multi #(
  parameter int W         = 10,
  parameter int NCH       = 2,
  parameter int DEPTH     = 1000,
  parameter int FRAME_LEN = 1000,
  parameter bit DESCEND   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_valid,
  output logic [NCH*W-1:0] out_data,
  output logic             is_final,
  output logic             mlp_en,
  output logic             busy
);

  localparam int DW  = NCH * W;
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam int DCW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  LAST_IN  = CW'(FRAME_LEN - 1);
  localparam logic [DCW-1:0] LAST_OUT = DCW'(DEPTH - 1);
  localparam logic [DCW-1:0] DRAIN_END = DCW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready is high for the whole LOAD state and never waits on in_valid.
  state_t         state;
  logic [CW-1:0]  in_cnt;
  logic [DCW-1:0] out_cnt;
  logic [DW-1:0]  cell_q [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] qual;
  logic [W-1:0]   new_key;
  logic           accept;
  logic           draining;

  assign new_key  = in_data[W-1:0];
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && (state == LOAD);
  assign draining = (state == DRAIN) && (out_cnt != DRAIN_END);

  // A cell qualifies if empty or strictly beaten; strictness keeps ties in arrival order.
  always_comb begin
    qual = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DESCEND) qual[i] = !occ[i] || (new_key > cell_q[i][W-1:0]);
      else         qual[i] = !occ[i] || (new_key < cell_q[i][W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      is_final  <= 1'b0;
      mlp_en    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      is_final  <= 1'b0;
      mlp_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            in_cnt <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            in_cnt <= in_cnt + CW'(1);
            if (in_cnt == LAST_IN) begin
              state   <= DRAIN;
              out_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          // One extra DRAIN cycle carries final, then mlp_en fires on the way to IDLE.
          if (out_cnt == DRAIN_END) begin
            state  <= IDLE;
            mlp_en <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_data  <= cell_q[0];
            out_cnt   <= out_cnt + DCW'(1);
            is_final  <= (out_cnt == LAST_OUT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Qualifying cells form a suffix of the chain, so the first one takes the new
  // sample and every later one takes its predecessor.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (state == IDLE && start) begin
      occ <= '0;
    end else if (accept) begin
      if (qual[0]) begin
        cell_q[0] <= in_data;
        occ[0]    <= 1'b1;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (qual[i]) begin
          if (qual[i-1]) begin
            cell_q[i] <= cell_q[i-1];
            occ[i]    <= occ[i-1];
          end else begin
            cell_q[i] <= in_data;
            occ[i]    <= 1'b1;
          end
        end
      end
    end else if (draining) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        cell_q[i] <= cell_q[i+1];
        occ[i]    <= occ[i+1];
      end
      occ[DEPTH-1] <= 1'b0;
    end
  end

endmodule
